conv_window_reader: RTL and testbench

CONV_WINDOW_READER -- requirements
Module: conv_window_reader

---
 rtl/conv_window_reader_pkg.sv | 22 ++
 rtl/conv_window_reader_if.sv | 27 ++
 rtl/conv_mac_unit.sv | 31 +++
 rtl/conv_window_reader.sv | 133 +++++++++++++
 tb/tb_conv_window_reader.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/conv_window_reader_pkg.sv
// Shared types and dimensions for the 4x4 / 3x3 convolution window reader.
// Four 2x2-output windows, each reduced by nine serial multiply-accumulates.
package conv_window_reader_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ACC_W   = 20;
    localparam int unsigned A_DIM   = 4;
    localparam int unsigned K_DIM   = 3;
    localparam int unsigned OUT_DIM = 2;

    localparam logic [1:0] TAP_LAST = 2'(K_DIM - 1);
    localparam logic [1:0] WIN_LAST = 2'(OUT_DIM * OUT_DIM - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StMac,
        StEmit,
        StFin
    } state_e;

endpackage

// File: rtl/conv_window_reader_if.sv
// Request, operand and result-stream signals of the convolution window reader.
interface conv_window_reader_if;
    import conv_window_reader_pkg::*;

    logic                              start;
    logic                              mem_done;
    logic [A_DIM*A_DIM*DATA_W-1:0]     a_flat;
    logic [K_DIM*K_DIM*DATA_W-1:0]     b_flat;
    logic                              busy;
    logic                              res_valid;
    logic                              res_ready;
    logic [ACC_W-1:0]                  res_data;
    logic [1:0]                        res_idx;
    logic                              done;
    logic                              err_not_ready;

    modport master (
        output start, mem_done, a_flat, b_flat, res_ready,
        input  busy, res_valid, res_data, res_idx, done, err_not_ready
    );

    modport slave (
        input  start, mem_done, a_flat, b_flat, res_ready,
        output busy, res_valid, res_data, res_idx, done, err_not_ready
    );

endinterface

// File: rtl/conv_mac_unit.sv
// 8x8 unsigned multiply feeding a 20-bit accumulator with synchronous clear and enable.
module conv_mac_unit
    import conv_window_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);

    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    acc_q;

    assign prod = a * b;
    assign acc  = acc_q;

    // 9 * 255 * 255 fits in ACC_W bits, so no saturation is needed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/conv_window_reader.sv
// Snapshots a 4x4 matrix and 3x3 kernel, then streams the four valid-window sums
// through a ready/valid port, one MAC per cycle.
module conv_window_reader
    import conv_window_reader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    conv_window_reader_if.slave  bus
);

    state_e                                  state_q;
    logic                                    busy_q;
    logic                                    res_valid_q;
    logic                                    done_q;
    logic                                    err_q;
    logic [1:0]                              window_q;
    logic [1:0]                              tap_row_q;
    logic [1:0]                              tap_col_q;
    logic [A_DIM*A_DIM-1:0][DATA_W-1:0]      a_snap_q;
    logic [K_DIM*K_DIM-1:0][DATA_W-1:0]      b_snap_q;

    logic [1:0]        a_row;
    logic [1:0]        a_col;
    logic [3:0]        b_idx;
    logic [DATA_W-1:0] a_op;
    logic [DATA_W-1:0] b_op;
    logic              last_tap;
    logic              handshake;
    logic              mac_clr;
    logic              mac_en;
    logic [ACC_W-1:0]  acc;

    // Window {row,col} offsets the tap position inside the 4x4 matrix.
    always_comb begin
        a_row     = tap_row_q + {1'b0, window_q[1]};
        a_col     = tap_col_q + {1'b0, window_q[0]};
        b_idx     = {1'b0, tap_row_q, 1'b0} + {2'b00, tap_row_q} + {2'b00, tap_col_q};
        a_op      = a_snap_q[{a_row, a_col}];
        b_op      = b_snap_q[b_idx];
        last_tap  = (tap_row_q == TAP_LAST) && (tap_col_q == TAP_LAST);
        handshake = (state_q == StEmit) && bus.res_ready;
        mac_clr   = (state_q == StLoad) || (handshake && (window_q != WIN_LAST));
        mac_en    = (state_q == StMac);
    end

    conv_mac_unit u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (a_op),
        .b   (b_op),
        .acc (acc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            window_q    <= '0;
            tap_row_q   <= '0;
            tap_col_q   <= '0;
            a_snap_q    <= '0;
            b_snap_q    <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        if (bus.mem_done) begin
                            state_q <= StLoad;
                            busy_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    a_snap_q  <= bus.a_flat;
                    b_snap_q  <= bus.b_flat;
                    window_q  <= '0;
                    tap_row_q <= '0;
                    tap_col_q <= '0;
                    state_q   <= StMac;
                end
                StMac: begin
                    if (last_tap) begin
                        tap_row_q   <= '0;
                        tap_col_q   <= '0;
                        res_valid_q <= 1'b1;
                        state_q     <= StEmit;
                    end else if (tap_col_q == TAP_LAST) begin
                        tap_col_q <= '0;
                        tap_row_q <= tap_row_q + 2'd1;
                    end else begin
                        tap_col_q <= tap_col_q + 2'd1;
                    end
                end
                StEmit: begin
                    if (handshake) begin
                        res_valid_q <= 1'b0;
                        if (window_q == WIN_LAST) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StFin;
                        end else begin
                            window_q <= window_q + 2'd1;
                            state_q  <= StMac;
                        end
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_data      = acc;
    assign bus.res_idx       = window_q;
    assign bus.done          = done_q;
    assign bus.err_not_ready = err_q;

endmodule

// File: tb/tb_conv_window_reader.sv
// Self-checking bench for conv_window_reader: directed table, corner sequences and
// randomized passes checked against a direct window-sum model.
module tb_conv_window_reader;
    import conv_window_reader_pkg::*;

    typedef struct {
        logic [127:0] a;
        logic [71:0]  b;
        int unsigned  stall;
        bit           corrupt;
        int unsigned  expv [4];
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    conv_window_reader_if bus();

    conv_window_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [127:0] rows_a(input logic [7:0] r0, input logic [7:0] r1,
                                            input logic [7:0] r2, input logic [7:0] r3);
        logic [127:0] v;
        logic [7:0]   rv [4];
        rv[0] = r0; rv[1] = r1; rv[2] = r2; rv[3] = r3;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                v[(r*4+c)*8 +: 8] = rv[r];
        return v;
    endfunction

    function automatic logic [71:0] rows_b(input logic [7:0] r0, input logic [7:0] r1,
                                           input logic [7:0] r2);
        logic [71:0] v;
        logic [7:0]  rv [3];
        rv[0] = r0; rv[1] = r1; rv[2] = r2;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                v[(r*3+c)*8 +: 8] = rv[r];
        return v;
    endfunction

    // Straight sum over the 3x3 footprint of window w = {row,col}.
    function automatic int unsigned model_sum(input logic [127:0] a, input logic [71:0] b,
                                              input int w);
        int unsigned s = 0;
        int unsigned av, bv;
        int wr = w / 2;
        int wc = w % 2;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                av = 32'(a[((wr+i)*4 + (wc+j))*8 +: 8]);
                bv = 32'(b[(i*3+j)*8 +: 8]);
                s += av * bv;
            end
        return s;
    endfunction

    task automatic run_pass(input logic [127:0] a, input logic [71:0] b,
                            input int unsigned stall, input bit corrupt,
                            input int unsigned expv [4]);
        int unsigned n_res = 0;
        int unsigned wait_cnt = 0;
        int unsigned base;
        int unsigned ncyc;
        bit          fin = 1'b0;
        bus.a_flat    = a;
        bus.b_flat    = b;
        bus.mem_done  = 1'b1;
        bus.res_ready = 1'b0;
        bus.start     = 1'b1;
        base = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        for (int t = 0; t < 400 && !fin; t++) begin
            ncyc = cyc - base;
            if (ncyc == 1) chk("busy_in_load", 32'(bus.busy), 32'd1);
            if (corrupt && ncyc == 4) begin
                bus.a_flat   = '0;
                bus.mem_done = 1'b0;
            end
            if (bus.done) begin
                fin = 1'b1;
                chk("done_cycle", ncyc, 42 + 4*stall);
                chk("results_before_done", n_res, 4);
                chk("busy_in_fin", 32'(bus.busy), 32'd0);
                bus.start     = 1'b0;
                bus.res_ready = 1'b0;
            end else begin
                if (bus.res_valid) begin
                    if (n_res == 0 && wait_cnt == 0) chk("first_valid_cycle", ncyc, 11);
                    if (n_res < 4) begin
                        chk("res_data", 32'(bus.res_data), expv[n_res]);
                        chk("res_idx", 32'(bus.res_idx), n_res);
                    end else begin
                        chk("result_count", n_res, 3);
                    end
                    if (wait_cnt >= stall) begin
                        bus.res_ready = 1'b1;
                        n_res++;
                        wait_cnt = 0;
                    end else begin
                        bus.res_ready = 1'b0;
                        wait_cnt++;
                    end
                end else begin
                    bus.res_ready = 1'($urandom_range(0, 1));
                end
                // Stray starts while busy must be ignored.
                bus.start = bus.busy ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(negedge clk);
        end
        chk("done_seen", 32'(fin), 32'd1);
        chk("done_pulse_width", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_valid", 32'(bus.res_valid), 32'd0);
        bus.start    = 1'b0;
        bus.mem_done = 1'b1;
    endtask

    logic [127:0] base_a;
    logic [71:0]  base_b;
    vec_t         vecs [4];
    int unsigned  ev [4];
    int unsigned  cnt;

    initial begin
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.mem_done  = 1'b0;
        bus.a_flat    = '0;
        bus.b_flat    = '0;
        bus.res_ready = 1'b0;
        base_a = rows_a(8'd3, 8'd4, 8'd9, 8'd14);
        base_b = rows_b(8'd11, 8'd2, 8'd9);

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_data", 32'(bus.res_data), 32'd0);
        chk("rst_idx", 32'(bus.res_idx), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err_not_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        vecs[0].a = base_a; vecs[0].b = base_b; vecs[0].stall = 0; vecs[0].corrupt = 1'b0;
        vecs[0].expv = '{366, 366, 564, 564};
        vecs[1].a = base_a; vecs[1].b = base_b; vecs[1].stall = 5; vecs[1].corrupt = 1'b0;
        vecs[1].expv = '{366, 366, 564, 564};
        vecs[2].a = '1;     vecs[2].b = '1;     vecs[2].stall = 0; vecs[2].corrupt = 1'b0;
        vecs[2].expv = '{585225, 585225, 585225, 585225};
        vecs[3].a = base_a; vecs[3].b = base_b; vecs[3].stall = 2; vecs[3].corrupt = 1'b1;
        vecs[3].expv = '{366, 366, 564, 564};
        for (int i = 0; i < 4; i++)
            run_pass(vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].corrupt, vecs[i].expv);

        // start while memory not ready
        bus.mem_done = 1'b0;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("err_pulse", 32'(bus.err_not_ready), 32'd1);
        chk("err_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("err_pulse_end", 32'(bus.err_not_ready), 32'd0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.res_valid || bus.busy || bus.done) cnt++;
            @(negedge clk);
        end
        chk("no_activity_after_err", cnt, 0);
        bus.mem_done = 1'b1;

        // reset during window 1 accumulation
        bus.a_flat    = base_a;
        bus.b_flat    = base_b;
        bus.res_ready = 1'b1;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 14; i++) @(negedge clk);
        chk("pre_reset_idx", 32'(bus.res_idx), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_valid", 32'(bus.res_valid), 32'd0);
        chk("mid_rst_data", 32'(bus.res_data), 32'd0);
        chk("mid_rst_idx", 32'(bus.res_idx), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.res_valid || bus.done || bus.busy) cnt++;
        end
        chk("no_activity_after_rst", cnt, 0);
        run_pass(base_a, base_b, 0, 1'b0, vecs[0].expv);

        for (int p = 0; p < 6; p++) begin
            logic [127:0] ra;
            logic [71:0]  rb;
            ra = {$urandom(), $urandom(), $urandom(), $urandom()};
            rb = {$urandom(), $urandom(), 8'($urandom())};
            for (int w = 0; w < 4; w++) ev[w] = model_sum(ra, rb, w);
            run_pass(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)), ev);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
